// File: rtl/d2d_pkg.sv
// d2d_pkg: shared definitions for the die-to-die adapter.
//   DATA_W / ADDR_W : payload widths.
//   d2d_beat_t      : one buffered transfer {data, addr[, parity]}.
//   d2d_parity      : even-parity helper (XOR reduction over data and address).
// Optional feature macro: D2D_PARITY_EN (adds a stored parity bit per beat).
package d2d_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
`ifdef D2D_PARITY_EN
        logic              parity;
`endif
    } d2d_beat_t;

    function automatic logic d2d_parity(input logic [DATA_W-1:0] data,
                                        input logic [ADDR_W-1:0] addr);
        return ^{data, addr};
    endfunction

endpackage

// File: rtl/d2d_sync_fifo.sv
// d2d_sync_fifo: single-clock storage for the adapter (array, pointers, count).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wr_en, wr_beat    write one beat (ignored when full)
//   rd_en, rd_beat    pop the head beat (ignored when empty); rd_beat is the head
//   full, empty       status decoded from the registered count
module d2d_sync_fifo
    import d2d_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  d2d_beat_t wr_beat,
    input  logic      rd_en,
    output d2d_beat_t rd_beat,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    d2d_beat_t        mem_q [DEPTH];
    d2d_beat_t        mem_d [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // Status flags and head entry from registered state only.
    always_comb begin
        full    = (count_q == (PTR_W+1)'(DEPTH));
        empty   = (count_q == '0);
        rd_beat = mem_q[rd_ptr_q];
        wr_ok   = wr_en && !full;
        rd_ok   = rd_en && !empty;
    end

    // Next-state: storage write, pointer advance (wraps modulo DEPTH), count update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_beat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/d2d_adapter.sv
// d2d_adapter: elastic valid/ready buffer at the chiplet boundary.
// Ports:
//   clk, rst_n                 clock; rst_n is a synchronous ACTIVE-HIGH reset
//   srcData/srcAddr/srcValid   source beat offer; srcReady = room available
//   dstData/dstAddr/dstValid   head beat (zeros when nothing valid); dstReady pops it
//   dstParity                  only with D2D_PARITY_EN: even parity of head {data, addr}
// Optional feature macro: D2D_PARITY_EN.
module d2d_adapter
    import d2d_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] srcData,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic              srcValid,
    output logic              srcReady,
    output logic [DATA_W-1:0] dstData,
    output logic [ADDR_W-1:0] dstAddr,
    output logic              dstValid,
`ifdef D2D_PARITY_EN
    output logic              dstParity,
`endif
    input  logic              dstReady
);

    d2d_beat_t wr_beat;
    d2d_beat_t head_beat;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;

    // Handshake glue: ready/valid derive only from registered count and reset,
    // so there is no combinational path from dstReady to srcReady.
    always_comb begin
        srcReady     = !full && !rst_n;
        dstValid     = !empty && !rst_n;
        push         = srcValid && srcReady;
        pop          = dstValid && dstReady;
        wr_beat      = '0;
        wr_beat.data = srcData;
        wr_beat.addr = srcAddr;
`ifdef D2D_PARITY_EN
        wr_beat.parity = d2d_parity(srcData, srcAddr);
`endif
    end

    // Output masking: payload is all zeros whenever no beat is presented.
    always_comb begin
        if (dstValid) begin
            dstData = head_beat.data;
            dstAddr = head_beat.addr;
`ifdef D2D_PARITY_EN
            dstParity = head_beat.parity;
`endif
        end else begin
            dstData = '0;
            dstAddr = '0;
`ifdef D2D_PARITY_EN
            dstParity = 1'b0;
`endif
        end
    end

    d2d_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (push),
        .wr_beat (wr_beat),
        .rd_en   (pop),
        .rd_beat (head_beat),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_d2d_adapter.sv
// Self-checking bench for d2d_adapter: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of an in-order buffer.
module tb_d2d_adapter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] srcData;
    logic [15:0] srcAddr;
    logic        srcValid;
    logic        srcReady;
    logic [31:0] dstData;
    logic [15:0] dstAddr;
    logic        dstValid;
    logic        dstReady;
`ifdef D2D_PARITY_EN
    logic        dstParity;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] a;
    } model_beat_t;

    model_beat_t mq[$];
    logic        last_sr;

    always #5 clk = ~clk;

    d2d_adapter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .srcData  (srcData),
        .srcAddr  (srcAddr),
        .srcValid (srcValid),
        .srcReady (srcReady),
        .dstData  (dstData),
        .dstAddr  (dstAddr),
        .dstValid (dstValid),
`ifdef D2D_PARITY_EN
        .dstParity(dstParity),
`endif
        .dstReady (dstReady)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic step(input logic r, input logic v, input logic [31:0] d,
                        input logic [15:0] a, input logic rdy);
        logic        e_sr, e_dv;
        logic [31:0] e_d;
        logic [15:0] e_a;
        model_beat_t nb;
        @(negedge clk);
        rst_n = r; srcValid = v; srcData = d; srcAddr = a; dstReady = rdy;
        #1;
        e_sr = !r && (mq.size() < DEPTH);
        e_dv = !r && (mq.size() != 0);
        e_d  = e_dv ? mq[0].d : 32'h0;
        e_a  = e_dv ? mq[0].a : 16'h0;
        chk("srcReady", {63'd0, srcReady}, {63'd0, e_sr});
        chk("dstValid", {63'd0, dstValid}, {63'd0, e_dv});
        chk("dstData",  {32'd0, dstData},  {32'd0, e_d});
        chk("dstAddr",  {48'd0, dstAddr},  {48'd0, e_a});
`ifdef D2D_PARITY_EN
        chk("dstParity", {63'd0, dstParity}, {63'd0, (e_dv ? ^{e_d, e_a} : 1'b0)});
`endif
        last_sr = e_sr;
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            if (e_dv && rdy) void'(mq.pop_front());
            if (v && e_sr) begin
                nb.d = d; nb.a = a;
                mq.push_back(nb);
            end
        end
    endtask

    // Spot check of outputs right after an edge against fixed expectations.
    task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                              input logic [15:0] a);
        #1;
        chk({tag, "_valid"}, {63'd0, dstValid}, {63'd0, v});
        chk({tag, "_data"},  {32'd0, dstData},  {32'd0, d});
        chk({tag, "_addr"},  {48'd0, dstAddr},  {48'd0, a});
    endtask

    initial begin
        logic        v, rdy, r;
        logic [31:0] d;
        logic [15:0] a;
        rst_n = 1'b1; srcValid = 1'b0; srcData = '0; srcAddr = '0; dstReady = 1'b0;
        last_sr = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 16'h0, 1'b0);

        // 1: first beat, held at dst
        step(1'b0, 1'b1, 32'hA5A5A5A5, 16'h0001, 1'b0);
        expect_out("t1", 1'b1, 32'hA5A5A5A5, 16'h0001);
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        expect_out("t1_hold", 1'b1, 32'hA5A5A5A5, 16'h0001);
        // 2: consume it
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        expect_out("t2", 1'b0, 32'h0, 16'h0);

        // 3: fill to DEPTH, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 32'(i), 16'(i), 1'b0);
        #1 chk("t3_full_ready", {63'd0, srcReady}, 64'd0);
        step(1'b0, 1'b1, 32'h55, 16'h55, 1'b1);   // dequeue while full: no enqueue
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);

        // 4: streaming, one beat per cycle
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(100 + i), 16'(i), 1'b1);
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);

        // 5: reset with 3 beats buffered
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'(200 + i), 16'(i), 1'b0);
        step(1'b1, 1'b1, 32'hDEAD, 16'hBEEF, 1'b1);
        step(1'b1, 1'b0, 32'h0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        expect_out("t5_no_stale", 1'b0, 32'h0, 16'h0);

`ifdef D2D_PARITY_EN
        // 6: parity spot checks
        step(1'b0, 1'b1, 32'h00000001, 16'h0000, 1'b0);
        #1 chk("t6_par1", {63'd0, dstParity}, 64'd1);
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        step(1'b0, 1'b1, 32'h00000003, 16'h0000, 1'b0);
        #1 chk("t6_par0", {63'd0, dstParity}, 64'd0);
        step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
`endif

        // Randomized traffic with varying back-pressure; source holds a stalled beat.
        v = 1'b0; d = '0; a = '0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!(v && !last_sr) || r) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
                a = 16'($urandom);
            end
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(r, v, d, a, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
